snow64_scalar_access_sequencer: RTL and testbench

- Sequences scalar loads and stores against 256-bit LAR data lines for the Snow64 core.
- Arbitrates one read requester and one write requester onto a single line-storage port.
- Fetches the addressed line, then either extracts a scalar through Snow64ScalarDataShifterForRead or merges one through Snow64ScalarDataShifterForWrite and writes the line back.
- No casting is performed; the requester supplies the type info.

---
 rtl/snow64_scalar_access_sequencer_pkg.sv | 104 ++++++++++
 rtl/snow64_scalar_access_sequencer_arbiter.sv | 57 +++++
 rtl/snow64_scalar_access_sequencer.sv | 159 +++++++++++++++
 tb/tb_snow64_scalar_access_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snow64_scalar_access_sequencer_pkg.sv
// Shared types and scalar lane helpers for the Snow64 scalar access sequencer.
package PkgSnow64ScalarAccessSequencer;

   localparam int FETCH_TIMEOUT_DEF   = 15;
   localparam int LAR_INDEX_WIDTH_DEF = 3;
   localparam int LINE_WIDTH          = 256;
   localparam int SCALAR_WIDTH        = 64;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRdFetch  = 3'd1,
      StRdResp   = 3'd2,
      StWrFetch  = 3'd3,
      StWrCommit = 3'd4
   } StSeq;

   typedef enum logic {
      GrantRead  = 1'b0,
      GrantWrite = 1'b1
   } Grant;

   typedef enum logic [1:0] {
      DataTypUnsgnInt = 2'd0,
      DataTypSgnInt   = 2'd1,
      DataTypBFloat16 = 2'd2,
      DataTypReserved = 2'd3
   } DataType;

   typedef enum logic [1:0] {
      IntTypSz8  = 2'd0,
      IntTypSz16 = 2'd1,
      IntTypSz32 = 2'd2,
      IntTypSz64 = 2'd3
   } IntTypeSize;

   // One latched request; the same layout serves both requesters.
   typedef struct packed {
      logic [LAR_INDEX_WIDTH_DEF-1:0] index;
      DataType                        data_type;
      IntTypeSize                     int_size;
      logic [4:0]                     offset;
      logic [SCALAR_WIDTH-1:0]        data;
   } ReqLatch;

   // log2 of the element size in bytes; BFloat16 is always a 16-bit lane.
   function automatic logic [1:0] elem_log2(input ReqLatch r);
      logic [1:0] lg;
      if (r.data_type == DataTypBFloat16) begin
         lg = 2'd1;
      end else begin
         lg = r.int_size;
      end
      return lg;
   endfunction

   // Bit position of the lane: offset rounded down to element alignment, times 8.
   function automatic logic [7:0] lane_shift(input ReqLatch r);
      logic [4:0] aligned;
      case (elem_log2(r))
         2'd0:    aligned = r.offset;
         2'd1:    aligned = {r.offset[4:1], 1'b0};
         2'd2:    aligned = {r.offset[4:2], 2'b00};
         2'd3:    aligned = {r.offset[4:3], 3'b000};
         default: aligned = 5'd0;
      endcase
      return {aligned, 3'b000};
   endfunction

   function automatic logic [SCALAR_WIDTH-1:0] scalar_mask(input ReqLatch r);
      logic [SCALAR_WIDTH-1:0] m;
      case (elem_log2(r))
         2'd0:    m = 64'h0000_0000_0000_00FF;
         2'd1:    m = 64'h0000_0000_0000_FFFF;
         2'd2:    m = 64'h0000_0000_FFFF_FFFF;
         2'd3:    m = 64'hFFFF_FFFF_FFFF_FFFF;
         default: m = 64'h0000_0000_0000_0000;
      endcase
      return m;
   endfunction

   // Read-side shifter: zero-extended lane, or zero for the reserved type.
   function automatic logic [SCALAR_WIDTH-1:0] scalar_extract(input logic [LINE_WIDTH-1:0] line,
                                                             input ReqLatch r);
      logic [SCALAR_WIDTH-1:0] lane;
      lane = SCALAR_WIDTH'(line >> lane_shift(r));
      if (r.data_type == DataTypReserved) begin
         lane = 64'd0;
      end else begin
         lane = lane & scalar_mask(r);
      end
      return lane;
   endfunction

   // Write-side shifter: replace one lane of the line with the low bits of data.
   function automatic logic [LINE_WIDTH-1:0] scalar_merge(input logic [LINE_WIDTH-1:0] line,
                                                         input ReqLatch r);
      logic [LINE_WIDTH-1:0] mask_w;
      logic [LINE_WIDTH-1:0] data_w;
      mask_w = {192'd0, scalar_mask(r)} << lane_shift(r);
      data_w = {192'd0, r.data & scalar_mask(r)} << lane_shift(r);
      return (line & ~mask_w) | data_w;
   endfunction

endpackage

// File: rtl/snow64_scalar_access_sequencer_arbiter.sv
// Two-way round-robin between the read and write requesters, active only while idle.
module snow64_scalar_access_arbiter
   import PkgSnow64ScalarAccessSequencer::*;
(
   input  logic clk,
   input  logic rst,
   input  logic idle_i,
   input  logic rd_valid_i,
   input  logic wr_valid_i,
   output logic rd_grant_o,
   output logic wr_grant_o
);

   Grant last_grant_q;
   Grant last_grant_d;

   // Grant decision: contested requests go to the side not served last.
   always_comb begin
      rd_grant_o   = 1'b0;
      wr_grant_o   = 1'b0;
      last_grant_d = last_grant_q;
      if (idle_i) begin
         if (rd_valid_i && wr_valid_i) begin
            if (last_grant_q == GrantWrite) begin
               rd_grant_o = 1'b1;
            end else begin
               wr_grant_o = 1'b1;
            end
         end else if (rd_valid_i) begin
            rd_grant_o = 1'b1;
         end else if (wr_valid_i) begin
            wr_grant_o = 1'b1;
         end else begin
            rd_grant_o = 1'b0;
         end
         if (rd_grant_o) begin
            last_grant_d = GrantRead;
         end else if (wr_grant_o) begin
            last_grant_d = GrantWrite;
         end else begin
            last_grant_d = last_grant_q;
         end
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // Remember who was accepted last; reset favours the read side first.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GrantWrite;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/snow64_scalar_access_sequencer.sv
// Serializes scalar loads/stores onto one 256-bit LAR line-storage port.
module snow64_scalar_access_sequencer
   import PkgSnow64ScalarAccessSequencer::*;
#(
   parameter int FETCH_TIMEOUT   = FETCH_TIMEOUT_DEF,
   parameter int LAR_INDEX_WIDTH = LAR_INDEX_WIDTH_DEF
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rd_req_valid,
   output logic                       rd_req_ready,
   input  logic [LAR_INDEX_WIDTH-1:0] rd_req_lar_index,
   input  logic [1:0]                 rd_req_data_type,
   input  logic [1:0]                 rd_req_int_type_size,
   input  logic [4:0]                 rd_req_data_offset,
   output logic                       rd_resp_valid,
   output logic [SCALAR_WIDTH-1:0]    rd_resp_data,
   input  logic                       wr_req_valid,
   output logic                       wr_req_ready,
   input  logic [LAR_INDEX_WIDTH-1:0] wr_req_lar_index,
   input  logic [1:0]                 wr_req_data_type,
   input  logic [1:0]                 wr_req_int_type_size,
   input  logic [4:0]                 wr_req_data_offset,
   input  logic [SCALAR_WIDTH-1:0]    wr_req_data,
   output logic                       wr_done,
   output logic                       line_rd_en,
   output logic [LAR_INDEX_WIDTH-1:0] line_addr,
   input  logic [LINE_WIDTH-1:0]      line_rd_data,
   input  logic                       line_rd_valid,
   output logic                       line_wr_en,
   output logic [LINE_WIDTH-1:0]      line_wr_data,
   output logic                       err_pulse,
   output logic                       busy
);

   localparam logic [3:0] TIMEOUT_LAST = 4'(FETCH_TIMEOUT - 1);

   StSeq                    state_q;
   ReqLatch                 req_q;
   logic [3:0]              cnt_q;
   logic                    rd_resp_valid_q;
   logic [SCALAR_WIDTH-1:0] rd_resp_data_q;
   logic                    wr_done_q;
   logic                    line_rd_en_q;
   logic                    line_wr_en_q;
   logic [LINE_WIDTH-1:0]   line_wr_data_q;
   logic                    err_pulse_q;
   ReqLatch                 rd_req_pkt;
   ReqLatch                 wr_req_pkt;

   // Pack each requester's fields into the shared latch layout.
   always_comb begin
      rd_req_pkt           = '0;
      rd_req_pkt.index     = rd_req_lar_index;
      rd_req_pkt.data_type = DataType'(rd_req_data_type);
      rd_req_pkt.int_size  = IntTypeSize'(rd_req_int_type_size);
      rd_req_pkt.offset    = rd_req_data_offset;
      wr_req_pkt           = '0;
      wr_req_pkt.index     = wr_req_lar_index;
      wr_req_pkt.data_type = DataType'(wr_req_data_type);
      wr_req_pkt.int_size  = IntTypeSize'(wr_req_int_type_size);
      wr_req_pkt.offset    = wr_req_data_offset;
      wr_req_pkt.data      = wr_req_data;
   end

   snow64_scalar_access_arbiter u_arbiter (
      .clk        (clk),
      .rst        (rst),
      .idle_i     (state_q == StIdle),
      .rd_valid_i (rd_req_valid),
      .wr_valid_i (wr_req_valid),
      .rd_grant_o (rd_req_ready),
      .wr_grant_o (wr_req_ready)
   );

   // Sequencer FSM: accept, fetch with timeout, then respond or commit; pulses last one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         req_q           <= '0;
         cnt_q           <= 4'd0;
         rd_resp_valid_q <= 1'b0;
         rd_resp_data_q  <= 64'd0;
         wr_done_q       <= 1'b0;
         line_rd_en_q    <= 1'b0;
         line_wr_en_q    <= 1'b0;
         line_wr_data_q  <= 256'd0;
         err_pulse_q     <= 1'b0;
      end else begin
         rd_resp_valid_q <= 1'b0;
         wr_done_q       <= 1'b0;
         line_wr_en_q    <= 1'b0;
         err_pulse_q     <= 1'b0;
         case (state_q)
            StIdle: begin
               cnt_q <= 4'd0;
               if (rd_req_ready) begin
                  req_q        <= rd_req_pkt;
                  line_rd_en_q <= 1'b1;
                  state_q      <= StRdFetch;
               end else if (wr_req_ready) begin
                  req_q        <= wr_req_pkt;
                  line_rd_en_q <= 1'b1;
                  state_q      <= StWrFetch;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRdFetch, StWrFetch: begin
               if (line_rd_valid) begin
                  line_rd_en_q <= 1'b0;
                  cnt_q        <= 4'd0;
                  if (state_q == StRdFetch) begin
                     rd_resp_data_q  <= scalar_extract(line_rd_data, req_q);
                     rd_resp_valid_q <= 1'b1;
                     state_q         <= StRdResp;
                  end else if (req_q.data_type == DataTypReserved) begin
                     err_pulse_q <= 1'b1;
                     state_q     <= StIdle;
                  end else begin
                     line_wr_data_q <= scalar_merge(line_rd_data, req_q);
                     line_wr_en_q   <= 1'b1;
                     wr_done_q      <= 1'b1;
                     state_q        <= StWrCommit;
                  end
               end else if (cnt_q == TIMEOUT_LAST) begin
                  line_rd_en_q <= 1'b0;
                  err_pulse_q  <= 1'b1;
                  cnt_q        <= 4'd0;
                  state_q      <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StRdResp: begin
               state_q <= StIdle;
            end
            StWrCommit: begin
               state_q <= StIdle;
            end
            default: begin
               line_rd_en_q <= 1'b0;
               state_q      <= StIdle;
            end
         endcase
      end
   end

   assign rd_resp_valid = rd_resp_valid_q;
   assign rd_resp_data  = rd_resp_data_q;
   assign wr_done       = wr_done_q;
   assign line_rd_en    = line_rd_en_q;
   assign line_addr     = req_q.index;
   assign line_wr_en    = line_wr_en_q;
   assign line_wr_data  = line_wr_data_q;
   assign err_pulse     = err_pulse_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_snow64_scalar_access_sequencer.sv
// Directed plus randomized bench for the scalar access sequencer, with a byte-level line model.
module tb_snow64_scalar_access_sequencer;

   localparam int FT = 15;

   logic         clk;
   logic         rst;
   logic         rd_req_valid;
   logic         rd_req_ready;
   logic [2:0]   rd_req_lar_index;
   logic [1:0]   rd_req_data_type;
   logic [1:0]   rd_req_int_type_size;
   logic [4:0]   rd_req_data_offset;
   logic         rd_resp_valid;
   logic [63:0]  rd_resp_data;
   logic         wr_req_valid;
   logic         wr_req_ready;
   logic [2:0]   wr_req_lar_index;
   logic [1:0]   wr_req_data_type;
   logic [1:0]   wr_req_int_type_size;
   logic [4:0]   wr_req_data_offset;
   logic [63:0]  wr_req_data;
   logic         wr_done;
   logic         line_rd_en;
   logic [2:0]   line_addr;
   logic [255:0] line_rd_data;
   logic         line_rd_valid;
   logic         line_wr_en;
   logic [255:0] line_wr_data;
   logic         err_pulse;
   logic         busy;

   int           total;
   int           bad;
   logic [255:0] mem [8];
   logic [63:0]  last_rd;

   snow64_scalar_access_sequencer #(
      .FETCH_TIMEOUT   (FT),
      .LAR_INDEX_WIDTH (3)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .rd_req_valid         (rd_req_valid),
      .rd_req_ready         (rd_req_ready),
      .rd_req_lar_index     (rd_req_lar_index),
      .rd_req_data_type     (rd_req_data_type),
      .rd_req_int_type_size (rd_req_int_type_size),
      .rd_req_data_offset   (rd_req_data_offset),
      .rd_resp_valid        (rd_resp_valid),
      .rd_resp_data         (rd_resp_data),
      .wr_req_valid         (wr_req_valid),
      .wr_req_ready         (wr_req_ready),
      .wr_req_lar_index     (wr_req_lar_index),
      .wr_req_data_type     (wr_req_data_type),
      .wr_req_int_type_size (wr_req_int_type_size),
      .wr_req_data_offset   (wr_req_data_offset),
      .wr_req_data          (wr_req_data),
      .wr_done              (wr_done),
      .line_rd_en           (line_rd_en),
      .line_addr            (line_addr),
      .line_rd_data         (line_rd_data),
      .line_rd_valid        (line_rd_valid),
      .line_wr_en           (line_wr_en),
      .line_wr_data         (line_wr_data),
      .err_pulse            (err_pulse),
      .busy                 (busy)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Element size in bytes: BFloat16 is 2, integers are 1,2,4,8.
   function automatic int elem_bytes(input logic [1:0] dt, input logic [1:0] sz);
      int nb;
      if (dt == 2'd2) nb = 2;
      else nb = 1 << int'(sz);
      return nb;
   endfunction

   // Expected read: copy the bytes of the aligned element, zero-extended.
   function automatic logic [63:0] model_extract(input logic [255:0] line, input logic [1:0] dt,
                                                 input logic [1:0] sz, input logic [4:0] off);
      logic [63:0] res;
      int nb;
      int base;
      res  = 64'd0;
      nb   = elem_bytes(dt, sz);
      base = (int'(off) / nb) * nb;
      if (dt != 2'd3) begin
         for (int b = 0; b < nb; b++) res[b*8 +: 8] = line[(base + b)*8 +: 8];
      end
      return res;
   endfunction

   // Expected line after a store: overwrite the aligned element's bytes with data bytes.
   function automatic logic [255:0] model_merge(input logic [255:0] line, input logic [1:0] dt,
                                                input logic [1:0] sz, input logic [4:0] off,
                                                input logic [63:0] data);
      logic [255:0] res;
      int nb;
      int base;
      res  = line;
      nb   = elem_bytes(dt, sz);
      base = (int'(off) / nb) * nb;
      for (int b = 0; b < nb; b++) res[(base + b)*8 +: 8] = data[b*8 +: 8];
      return res;
   endfunction

   task automatic set_rd(input logic [2:0] idx, input logic [1:0] dt, input logic [1:0] sz,
                         input logic [4:0] off);
      rd_req_lar_index     = idx;
      rd_req_data_type     = dt;
      rd_req_int_type_size = sz;
      rd_req_data_offset   = off;
   endtask

   task automatic set_wr(input logic [2:0] idx, input logic [1:0] dt, input logic [1:0] sz,
                         input logic [4:0] off, input logic [63:0] data);
      wr_req_lar_index     = idx;
      wr_req_data_type     = dt;
      wr_req_int_type_size = sz;
      wr_req_data_offset   = off;
      wr_req_data          = data;
   endtask

   // Called just after the accept edge: idle `delay` cycles, then return the line for one edge.
   task automatic serve_fetch(input logic [2:0] idx, input int delay);
      check("fetch_rd_en", 256'(line_rd_en), 256'(1));
      check("fetch_addr", 256'(line_addr), 256'(idx));
      for (int i = 0; i < delay; i++) begin
         tick();
         check("busy_no_ready", 256'({rd_req_ready, wr_req_ready}), 256'(0));
         check("busy_flag", 256'(busy), 256'(1));
      end
      line_rd_data  = mem[idx];
      line_rd_valid = 1'b1;
      tick();
      line_rd_valid = 1'b0;
      line_rd_data  = 256'd0;
      check("fetch_rd_en_drop", 256'(line_rd_en), 256'(0));
   endtask

   task automatic do_read(input logic [2:0] idx, input logic [1:0] dt, input logic [1:0] sz,
                          input logic [4:0] off, input int delay);
      logic [63:0] exp;
      set_rd(idx, dt, sz, off);
      rd_req_valid = 1'b1;
      #1;
      check("rd_ready", 256'(rd_req_ready), 256'(1));
      tick();
      rd_req_valid = 1'b0;
      serve_fetch(idx, delay);
      exp     = model_extract(mem[idx], dt, sz, off);
      last_rd = exp;
      check("rd_resp_valid", 256'(rd_resp_valid), 256'(1));
      check("rd_resp_data", 256'(rd_resp_data), 256'(exp));
      check("rd_no_err", 256'(err_pulse), 256'(0));
      tick();
      check("rd_resp_pulse_end", 256'(rd_resp_valid), 256'(0));
      check("rd_idle", 256'(busy), 256'(0));
   endtask

   task automatic do_write(input logic [2:0] idx, input logic [1:0] dt, input logic [1:0] sz,
                           input logic [4:0] off, input logic [63:0] data, input int delay);
      logic [255:0] exp;
      set_wr(idx, dt, sz, off, data);
      wr_req_valid = 1'b1;
      #1;
      check("wr_ready", 256'(wr_req_ready), 256'(1));
      tick();
      wr_req_valid = 1'b0;
      serve_fetch(idx, delay);
      if (dt == 2'd3) begin
         check("wr_rsv_no_en", 256'(line_wr_en), 256'(0));
         check("wr_rsv_no_done", 256'(wr_done), 256'(0));
         check("wr_rsv_err", 256'(err_pulse), 256'(1));
      end else begin
         exp      = model_merge(mem[idx], dt, sz, off, data);
         mem[idx] = exp;
         check("wr_en", 256'(line_wr_en), 256'(1));
         check("wr_done", 256'(wr_done), 256'(1));
         check("wr_data", line_wr_data, exp);
         check("wr_no_err", 256'(err_pulse), 256'(0));
      end
      tick();
      check("wr_en_end", 256'(line_wr_en), 256'(0));
      check("wr_done_end", 256'(wr_done), 256'(0));
      check("wr_err_end", 256'(err_pulse), 256'(0));
      check("wr_idle", 256'(busy), 256'(0));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      rd_req_valid = 1'b0;
      wr_req_valid = 1'b0;
      set_rd(3'd0, 2'd0, 2'd0, 5'd0);
      set_wr(3'd0, 2'd0, 2'd0, 5'd0, 64'd0);
      line_rd_data  = 256'd0;
      line_rd_valid = 1'b0;
      last_rd       = 64'd0;
      for (int i = 0; i < 8; i++) begin
         for (int w = 0; w < 8; w++) mem[i][w*32 +: 32] = $urandom;
      end
      repeat (3) tick();

      // Reset state
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_rd_en", 256'(line_rd_en), 256'(0));
      check("rst_wr_en", 256'(line_wr_en), 256'(0));
      check("rst_resp", 256'({rd_resp_valid, wr_done, err_pulse}), 256'(0));
      check("rst_resp_data", 256'(rd_resp_data), 256'(0));
      check("rst_wr_data", line_wr_data, 256'(0));
      rst = 1'b0;
      tick();

      // Both requesters held from reset: read, write, read
      set_rd(3'd4, 2'd0, 2'd3, 5'd0);
      set_wr(3'd5, 2'd0, 2'd3, 5'd8, 64'h0123_4567_89AB_CDEF);
      rd_req_valid = 1'b1;
      wr_req_valid = 1'b1;
      #1;
      check("arb1_rd_ready", 256'(rd_req_ready), 256'(1));
      check("arb1_wr_ready", 256'(wr_req_ready), 256'(0));
      tick();
      serve_fetch(3'd4, 1);
      check("arb1_resp", 256'(rd_resp_valid), 256'(1));
      check("arb1_data", 256'(rd_resp_data), 256'(model_extract(mem[4], 2'd0, 2'd3, 5'd0)));
      tick();
      check("arb2_wr_ready", 256'(wr_req_ready), 256'(1));
      check("arb2_rd_ready", 256'(rd_req_ready), 256'(0));
      tick();
      serve_fetch(3'd5, 2);
      mem[5] = model_merge(mem[5], 2'd0, 2'd3, 5'd8, 64'h0123_4567_89AB_CDEF);
      check("arb2_done", 256'(wr_done), 256'(1));
      check("arb2_data", line_wr_data, mem[5]);
      tick();
      check("arb3_rd_ready", 256'(rd_req_ready), 256'(1));
      check("arb3_wr_ready", 256'(wr_req_ready), 256'(0));
      tick();
      serve_fetch(3'd4, 1);
      check("arb3_resp", 256'(rd_resp_valid), 256'(1));
      last_rd = model_extract(mem[4], 2'd0, 2'd3, 5'd0);
      tick();
      rd_req_valid = 1'b0;
      wr_req_valid = 1'b0;

      // BFloat16 read at offset 6
      mem[1][63:48] = 16'hBEEF;
      do_read(3'd1, 2'd2, 2'd0, 5'd6, 1);
      check("bf16_const", 256'(rd_resp_data), 256'(64'h0000_0000_0000_BEEF));

      // 32-bit read at offset 13 truncates to lane 3
      mem[2][127:96] = 32'hCAFE_F00D;
      do_read(3'd2, 2'd0, 2'd2, 5'd13, 1);
      check("u32_const", 256'(rd_resp_data), 256'(64'h0000_0000_CAFE_F00D));

      // BFloat16 write into an all-ones line, then read it back
      mem[3] = {256{1'b1}};
      do_write(3'd3, 2'd2, 2'd0, 5'd0, 64'h0000_0000_0000_1234, 1);
      check("bf16_wr_line", mem[3], {{240{1'b1}}, 16'h1234});
      do_read(3'd3, 2'd0, 2'd1, 5'd1, 2);
      check("bf16_readback", 256'(rd_resp_data), 256'(64'h1234));

      // Reserved read returns zero; reserved write flags an error
      do_read(3'd6, 2'd3, 2'd2, 5'd4, 1);
      do_write(3'd7, 2'd3, 2'd1, 5'd2, 64'hFFFF, 1);

      // Fetch timeout on a read
      set_rd(3'd0, 2'd0, 2'd0, 5'd0);
      rd_req_valid = 1'b1;
      tick();
      rd_req_valid = 1'b0;
      for (int i = 1; i < FT; i++) begin
         tick();
         check("to_wait_err", 256'(err_pulse), 256'(0));
         check("to_wait_busy", 256'(busy), 256'(1));
      end
      tick();
      check("to_err", 256'(err_pulse), 256'(1));
      check("to_busy", 256'(busy), 256'(0));
      check("to_no_resp", 256'(rd_resp_valid), 256'(0));
      check("to_rd_en", 256'(line_rd_en), 256'(0));
      check("to_data_held", 256'(rd_resp_data), 256'(last_rd));
      tick();
      check("to_err_end", 256'(err_pulse), 256'(0));

      // Randomized traffic against the line model
      for (int n = 0; n < 60; n++) begin
         logic [2:0]  idx;
         logic [1:0]  dt;
         logic [1:0]  sz;
         logic [4:0]  off;
         logic [63:0] data;
         int          dly;
         idx  = 3'($urandom_range(0, 7));
         dt   = 2'($urandom_range(0, 3));
         sz   = 2'($urandom_range(0, 3));
         off  = 5'($urandom_range(0, 31));
         data = {$urandom, $urandom};
         dly  = int'($urandom_range(1, 4));
         if ($urandom_range(0, 1) == 0) do_read(idx, dt, sz, off, dly);
         else do_write(idx, dt, sz, off, data, dly);
      end

      // Reset during a write fetch with the line arriving on the same edge
      set_wr(3'd6, 2'd0, 2'd3, 5'd0, 64'hDEAD_BEEF_DEAD_BEEF);
      wr_req_valid = 1'b1;
      tick();
      wr_req_valid = 1'b0;
      tick();
      line_rd_data  = mem[6];
      line_rd_valid = 1'b1;
      rst           = 1'b1;
      tick();
      rst           = 1'b0;
      line_rd_valid = 1'b0;
      check("rstw_wr_en", 256'(line_wr_en), 256'(0));
      check("rstw_done", 256'(wr_done), 256'(0));
      check("rstw_misc", 256'({rd_resp_valid, err_pulse, busy, line_rd_en}), 256'(0));
      check("rstw_resp_data", 256'(rd_resp_data), 256'(0));
      check("rstw_wr_data", line_wr_data, 256'(0));
      check("rstw_addr", 256'(line_addr), 256'(0));
      tick();
      check("rstw_wr_en2", 256'(line_wr_en), 256'(0));
      check("rstw_done2", 256'(wr_done), 256'(0));
      rd_req_valid = 1'b1;
      wr_req_valid = 1'b1;
      #1;
      check("rstw_read_first", 256'({rd_req_ready, wr_req_ready}), 256'(2));
      rd_req_valid = 1'b0;
      wr_req_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
